// File: rtl/me_pkg.sv
// Shared types and geometry for the motion-estimation window loader.
package me_pkg;

    localparam int DATA_W  = 8;
    localparam int R_DIM   = 16;
    localparam int S_DIM   = 32;
    localparam int R_WORDS = R_DIM * R_DIM;
    localparam int S_WORDS = S_DIM * S_DIM;
    localparam int R_AW    = $clog2(R_WORDS);
    localparam int S_AW    = $clog2(S_WORDS);
    // One counter spans the R load followed by the S load.
    localparam int CNT_W   = $clog2(R_WORDS + S_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_R = 2'd1,
        LOAD_S = 2'd2,
        RUN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] motion_x;
        logic [3:0] motion_y;
        logic [7:0] best_dist;
    } result_t;

endpackage

// File: rtl/me_window_loader.sv
// Loader front end: streams bytes into the R then S memories, runs the ME core,
// and latches its result.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for load_req; stream ignored
// LOAD_R | writing the 16x16 reference block, count 0..255
// LOAD_S | writing the 32x32 search window, count 256..1279
// RUN    | me_start held high until me_completed, then result latched
module me_window_loader
    import me_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              r_we,
    output logic [R_AW-1:0]   r_waddr,
    output logic [DATA_W-1:0] r_wdata,
    output logic              s_we,
    output logic [S_AW-1:0]   s_waddr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              me_start,
    input  logic              me_completed,
    input  logic [3:0]        me_motion_x,
    input  logic [3:0]        me_motion_y,
    input  logic [7:0]        me_best_dist,
    output logic              busy,
    output logic              result_valid,
    output logic [3:0]        result_motion_x,
    output logic [3:0]        result_motion_y,
    output logic [7:0]        result_best_dist
);

    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R_WORDS - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(R_WORDS + S_WORDS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             ready_q, start_q, busy_q, rvalid_q;
    result_t          result_q;
    logic             accept, finish;

    assign accept = data_valid & ready_q;
    assign finish = (state == RUN) & me_completed;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (load_req)                     state_nxt = LOAD_R;
            LOAD_R:  if (accept && (count == R_LAST))  state_nxt = LOAD_S;
            LOAD_S:  if (accept && (count == S_LAST))  state_nxt = RUN;
            RUN:     if (me_completed)                 state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    // State register plus registered decodes of the next state, so ready,
    // start and busy come straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == LOAD_R) || (state_nxt == LOAD_S);
            start_q <= (state_nxt == RUN);
            busy_q  <= (state_nxt != IDLE);
        end
    end

    // Byte counter: cleared when a load begins, advances per accepted byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if ((state == IDLE) && load_req) begin
            count <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
        end
    end

    // Result capture on the first completed cycle of RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid_q <= 1'b0;
            result_q <= '0;
        end else begin
            rvalid_q <= finish;
            if (finish) begin
                result_q <= '{motion_x: me_motion_x, motion_y: me_motion_y,
                              best_dist: me_best_dist};
            end
        end
    end

    assign data_ready = ready_q;
    assign me_start   = start_q;
    assign busy       = busy_q;

    // S addresses are count-256; the low 10 bits alone give that modulo 1024.
    assign r_we    = accept & (state == LOAD_R);
    assign r_waddr = count[R_AW-1:0];
    assign r_wdata = data_in;
    assign s_we    = accept & (state == LOAD_S);
    assign s_waddr = (state == LOAD_S) ? (count[S_AW-1:0] - S_AW'(R_WORDS)) : '0;
    assign s_wdata = data_in;

    assign result_valid     = rvalid_q;
    assign result_motion_x  = result_q.motion_x;
    assign result_motion_y  = result_q.motion_y;
    assign result_best_dist = result_q.best_dist;

endmodule

// File: tb/tb_me_window_loader.sv
// Randomised self-checking bench for me_window_loader against a transaction-level model.
module tb_me_window_loader;
    import me_pkg::*;

    logic              clock, reset, load_req, data_valid, data_ready;
    logic [DATA_W-1:0] data_in, r_wdata, s_wdata;
    logic              r_we, s_we, me_start, me_completed, busy, result_valid;
    logic [R_AW-1:0]   r_waddr;
    logic [S_AW-1:0]   s_waddr;
    logic [3:0]        me_motion_x, me_motion_y, result_motion_x, result_motion_y;
    logic [7:0]        me_best_dist, result_best_dist;

    int tests = 0;
    int fails = 0;

    // model: a load is "in progress" with n bytes taken, or the core is "running"
    bit        m_loading = 0;
    bit        m_running = 0;
    bit        m_pend_rv = 0;
    int        m_n = 0;
    logic [15:0] m_res = '0;

    me_window_loader dut (
        .clock(clock), .reset(reset), .load_req(load_req), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready),
        .r_we(r_we), .r_waddr(r_waddr), .r_wdata(r_wdata),
        .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .me_start(me_start), .me_completed(me_completed),
        .me_motion_x(me_motion_x), .me_motion_y(me_motion_y), .me_best_dist(me_best_dist),
        .busy(busy), .result_valid(result_valid),
        .result_motion_x(result_motion_x), .result_motion_y(result_motion_y),
        .result_best_dist(result_best_dist)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle of the reference model, evaluated mid-cycle before the next posedge.
    task automatic model_step();
        bit exp_r, exp_s;
        if (!reset) begin
            check("rst_ready", data_ready, 0);
            check("rst_we", {r_we, s_we}, 0);
            check("rst_start", me_start, 0);
            check("rst_busy", busy, 0);
            check("rst_rvalid", result_valid, 0);
            check("rst_result", {result_motion_x, result_motion_y, result_best_dist}, 0);
            m_loading = 0; m_running = 0; m_pend_rv = 0; m_n = 0; m_res = '0;
        end else begin
            check("ready", data_ready, m_loading);
            check("busy", busy, m_loading || m_running);
            check("start", me_start, m_running);
            check("rvalid", result_valid, m_pend_rv);
            check("result", {result_motion_x, result_motion_y, result_best_dist}, m_res);
            m_pend_rv = 0;
            exp_r = m_loading && data_valid && (m_n < R_WORDS);
            exp_s = m_loading && data_valid && (m_n >= R_WORDS);
            check("r_we", r_we, exp_r);
            check("s_we", s_we, exp_s);
            if (exp_r) begin
                check("r_waddr", r_waddr, m_n);
                check("r_wdata", r_wdata, data_in);
            end
            if (exp_s) begin
                check("s_waddr", s_waddr, m_n - R_WORDS);
                check("s_wdata", s_wdata, data_in);
            end
            if (m_loading) begin
                if (data_valid) begin
                    m_n++;
                    if (m_n == R_WORDS + S_WORDS) begin
                        m_loading = 0;
                        m_running = 1;
                    end
                end
            end else if (m_running) begin
                if (me_completed) begin
                    m_res = {me_motion_x, me_motion_y, me_best_dist};
                    m_pend_rv = 1;
                    m_running = 0;
                end
            end else if (load_req) begin
                m_loading = 1;
                m_n = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            model_step();
        end
    end

    // mode 0: valid always, data = byte index; 1: valid every other cycle;
    // 2: random valid. Modes 1/2 also scatter stray load_req pulses.
    task automatic do_load(input int mode, input int limit, output int cycles);
        int n = 0;
        int cyc = 0;
        @(posedge clock); #1;
        load_req = 1'b1;
        data_valid = 1'($urandom_range(0, 1));
        data_in = 8'($urandom);
        @(posedge clock); #1;
        load_req = 1'b0;
        while (n < limit && cyc < 20000) begin
            case (mode)
                0:       data_valid = 1'b1;
                1:       data_valid = (cyc % 2 == 0);
                default: data_valid = ($urandom_range(0, 3) != 0);
            endcase
            data_in  = (mode == 0) ? n[7:0] : 8'($urandom);
            load_req = (mode != 0) && ($urandom_range(0, 15) == 0);
            @(negedge clock);
            if (data_valid && data_ready) n++;
            cyc++;
            @(posedge clock); #1;
        end
        check("load_bytes", n, limit);
        data_valid = 1'b0;
        load_req = 1'b0;
        cycles = cyc;
    endtask

    // Idle in RUN with ignored stimulus, then complete; completed stays high one
    // extra cycle as the core would while start is still seen high.
    task automatic run_phase(input int wait_cyc, input logic [3:0] x, input logic [3:0] y,
                             input logic [7:0] d, input bit same_req);
        repeat (wait_cyc) begin
            data_valid = 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
            load_req = ($urandom_range(0, 3) == 0);
            @(posedge clock); #1;
        end
        data_valid = 1'b0;
        me_completed = 1'b1;
        me_motion_x = x; me_motion_y = y; me_best_dist = d;
        load_req = same_req;
        @(posedge clock); #1;
        load_req = 1'b0;
        me_motion_x = 4'($urandom); me_motion_y = 4'($urandom); me_best_dist = 8'($urandom);
        @(negedge clock);
        check("t4_rvalid", result_valid, 1);
        check("t4_x", result_motion_x, x);
        check("t4_y", result_motion_y, y);
        check("t4_dist", result_best_dist, d);
        check("t4_start", me_start, 0);
        check("t4_busy", busy, 0);
        @(posedge clock); #1;
        me_completed = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy_direct", busy, 0);
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        int cyc;
        reset = 1'b0; load_req = 1'b0; data_valid = 1'b0; data_in = '0;
        me_completed = 1'b0; me_motion_x = '0; me_motion_y = '0; me_best_dist = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // idle with random valid traffic: nothing may be written
        repeat (10) begin
            data_valid = 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
            @(posedge clock); #1;
        end
        data_valid = 1'b0;

        do_load(0, R_WORDS + S_WORDS, cyc);
        check("t2_cycles", cyc, 1280);
        run_phase(3, 4'h3, 4'hE, 8'h12, 1'b0);

        do_load(1, R_WORDS + S_WORDS, cyc);
        check("t3_cycles", cyc, 2559);
        run_phase(5, 4'($urandom), 4'($urandom), 8'($urandom), 1'b1);

        // reset while RUN is waiting on the core clears the result too
        do_load(2, R_WORDS + S_WORDS, cyc);
        repeat (4) @(posedge clock);
        #1 pulse_reset();

        // reset after the 500th accepted byte, then a clean restart
        do_load(2, 500, cyc);
        pulse_reset();
        do_load(2, R_WORDS + S_WORDS, cyc);
        run_phase(2, 4'($urandom), 4'($urandom), 8'($urandom), 1'b0);

        repeat (2) begin
            do_load(2, R_WORDS + S_WORDS, cyc);
            run_phase($urandom_range(0, 6), 4'($urandom), 4'($urandom), 8'($urandom),
                      1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(posedge clock);
            #1;
        end

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
